// File: rtl/dmem_wbuf_if.sv
// Core data-port bundle for dmem_wbuf: load/store requests from the core,
// load data, stall, buffer status and sticky error flags back to the core.
interface dmem_wbuf_if;
    logic        data_re;
    logic [31:0] data_raddr;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        data_we;
    logic [31:0] data_waddr;
    logic [31:0] data_wdata;
    logic        data_stall;
    logic        wbuf_empty;
    logic        err_misalign;
    logic        err_range;

    modport master (
        output data_re, data_raddr, data_we, data_waddr, data_wdata,
        input  data_rdata, data_rvalid, data_stall, wbuf_empty,
        input  err_misalign, err_range
    );

    modport slave (
        input  data_re, data_raddr, data_we, data_waddr, data_wdata,
        output data_rdata, data_rvalid, data_stall, wbuf_empty,
        output err_misalign, err_range
    );
endinterface

// File: rtl/dmem_wbuf.sv
// Word data memory with posted in-order write buffer and load forwarding.
// Ports: clk, rst (async, active-high), bus (dmem_wbuf_if.slave).
module dmem_wbuf #(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          WBUF_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    dmem_wbuf_if.slave   bus
);
    localparam int PW    = $clog2(WBUF_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_MEM,
        SRC_FWD
    } rd_src_t;

    logic [31:0]       mem [WORDS];
    logic [ADDR_W-1:0] buf_idx [WBUF_DEPTH];
    logic [31:0]       buf_data [WBUF_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0] mem_rd;
    logic [31:0] fwd_q;
    rd_src_t     src_q;
    logic        rvalid_q;
    logic        err_mis_q;
    logic        err_rng_q;

    // BASE_ADDR is word aligned, so offset low bits equal address low bits.
    logic [31:0]       r_off;
    logic [31:0]       w_off;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx;
    logic              r_in;
    logic              w_in;

    assign r_off = bus.data_raddr - BASE_ADDR;
    assign w_off = bus.data_waddr - BASE_ADDR;
    assign r_idx = r_off[ADDR_W+1:2];
    assign w_idx = w_off[ADDR_W+1:2];
    // Addresses below BASE_ADDR wrap to huge offsets and land out of range.
    assign r_in  = (r_off >> (ADDR_W + 2)) == 32'd0;
    assign w_in  = (w_off >> (ADDR_W + 2)) == 32'd0;

    logic full;
    logic rd_acc;
    logic wr_acc;
    logic push;
    logic drain;

    assign full   = (count == CW'(WBUF_DEPTH));
    assign rd_acc = bus.data_re & ~full;
    assign wr_acc = bus.data_we & ~full;
    assign push   = wr_acc & w_in;
    // A load owns the array port; otherwise the head entry drains.
    assign drain  = full | (~bus.data_re & (count != '0));

    // Walk oldest to youngest so the youngest match is left standing.
    logic        fwd_hit;
    logic [31:0] fwd_data;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if ((CW'(i) < count) &&
                (buf_idx[head + PW'(i)] == r_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[head + PW'(i)];
            end
        end
    end

    // Array and buffer storage carry no reset.
    always_ff @(posedge clk) begin
        if (drain) begin
            mem[buf_idx[head]] <= buf_data[head];
        end
        if (rd_acc) begin
            mem_rd <= mem[r_idx];
        end
        if (push) begin
            buf_idx[tail]  <= w_idx;
            buf_data[tail] <= bus.data_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            unique case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            src_q    <= SRC_ZERO;
            fwd_q    <= '0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                fwd_q <= fwd_data;
                if (!r_in) begin
                    src_q <= SRC_ZERO;
                end else if (fwd_hit) begin
                    src_q <= SRC_FWD;
                end else begin
                    src_q <= SRC_MEM;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_mis_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            if ((rd_acc && r_off[1:0] != 2'b00) ||
                (wr_acc && w_off[1:0] != 2'b00)) begin
                err_mis_q <= 1'b1;
            end
            if ((rd_acc && !r_in) || (wr_acc && !w_in)) begin
                err_rng_q <= 1'b1;
            end
        end
    end

    logic [31:0] rdata;

    // Source select is only updated on accepted loads, so data holds.
    always_comb begin
        rdata = '0;
        unique case (src_q)
            SRC_MEM: rdata = mem_rd;
            SRC_FWD: rdata = fwd_q;
            default: rdata = '0;
        endcase
    end

    assign bus.data_rdata   = rdata;
    assign bus.data_rvalid  = rvalid_q;
    assign bus.data_stall   = full & (bus.data_re | bus.data_we);
    assign bus.wbuf_empty   = (count == '0);
    assign bus.err_misalign = err_mis_q;
    assign bus.err_range    = err_rng_q;
endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: reset, forwarding, ordering, stall,
// same-cycle load/store and error flags against hand-computed values.
module tb_dmem_wbuf;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_wbuf_if bus ();

    dmem_wbuf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic re, input logic [31:0] ra,
                          input logic we, input logic [31:0] wa,
                          input logic [31:0] wd);
        bus.data_re    = re;
        bus.data_raddr = ra;
        bus.data_we    = we;
        bus.data_waddr = wa;
        bus.data_wdata = wd;
    endtask

    task automatic idle();
        set_in(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        idle();
        while (!bus.wbuf_empty && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", {31'd0, bus.wbuf_empty}, 32'd1);
    endtask

    task automatic load(input logic [31:0] a, input string tag,
                        input logic [31:0] exp);
        set_in(1'b1, a, 1'b0, 32'd0, 32'd0);
        tick();
        idle();
        chk({tag, "_v"}, {31'd0, bus.data_rvalid}, 32'd1);
        chk(tag, bus.data_rdata, exp);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t init_tab[7] = '{
        '{32'h00, 32'hA0A0_0000}, '{32'h10, 32'h1111_1111},
        '{32'h20, 32'h2222_2222}, '{32'h30, 32'h0000_0005},
        '{32'h40, 32'h0000_0040}, '{32'h44, 32'h0000_0044},
        '{32'h48, 32'h0000_0048}
    };

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        #12;
        chk("rst_rvalid", {31'd0, bus.data_rvalid}, 32'd0);
        chk("rst_rdata", bus.data_rdata, 32'd0);
        chk("rst_empty", {31'd0, bus.wbuf_empty}, 32'd1);
        chk("rst_errm", {31'd0, bus.err_misalign}, 32'd0);
        chk("rst_errr", {31'd0, bus.err_range}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (init_tab[i]) begin
            set_in(1'b0, 32'd0, 1'b1, init_tab[i].a, init_tab[i].d);
            tick();
        end
        wait_empty();

        // Three stores parked behind loads, then async reset.
        set_in(1'b1, 32'h00, 1'b1, 32'h40, 32'hBAD0_0040);
        tick();
        set_in(1'b1, 32'h00, 1'b1, 32'h44, 32'hBAD0_0044);
        tick();
        set_in(1'b1, 32'h00, 1'b1, 32'h48, 32'hBAD0_0048);
        tick();
        idle();
        chk("t1_busy", {31'd0, bus.wbuf_empty}, 32'd0);
        chk("t1_ld0", bus.data_rdata, 32'hA0A0_0000);
        #1;
        rst = 1'b1;
        #1;
        chk("t1_empty", {31'd0, bus.wbuf_empty}, 32'd1);
        chk("t1_rvalid", {31'd0, bus.data_rvalid}, 32'd0);
        rst = 1'b0;
        tick();
        load(32'h40, "t1_ld40", 32'h0000_0040);
        load(32'h44, "t1_ld44", 32'h0000_0044);
        load(32'h48, "t1_ld48", 32'h0000_0048);

        // Store then forwarded load.
        set_in(1'b0, 32'd0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        tick();
        set_in(1'b1, 32'h10, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t2_busy", {31'd0, bus.wbuf_empty}, 32'd0);
        tick();
        idle();
        chk("t2_v", {31'd0, bus.data_rvalid}, 32'd1);
        chk("t2_fwd", bus.data_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_vlo", {31'd0, bus.data_rvalid}, 32'd0);
        chk("t2_hold", bus.data_rdata, 32'hDEAD_BEEF);
        wait_empty();

        // Two stores to one word, last wins.
        set_in(1'b0, 32'd0, 1'b1, 32'h20, 32'd1);
        tick();
        set_in(1'b0, 32'd0, 1'b1, 32'h20, 32'd2);
        tick();
        load(32'h20, "t3_fwd", 32'd2);
        wait_empty();
        load(32'h20, "t3_arr", 32'd2);

        // Fill the buffer behind loads, stall once.
        set_in(1'b1, 32'h10, 1'b1, 32'h80, 32'hA1);
        tick();
        chk("t4_c1", bus.data_rdata, 32'hDEAD_BEEF);
        set_in(1'b1, 32'h80, 1'b1, 32'h84, 32'hA2);
        tick();
        chk("t4_c2", bus.data_rdata, 32'hA1);
        set_in(1'b1, 32'h84, 1'b1, 32'h88, 32'hA3);
        tick();
        chk("t4_c3", bus.data_rdata, 32'hA2);
        set_in(1'b1, 32'h88, 1'b1, 32'h8C, 32'hA4);
        tick();
        chk("t4_c4", bus.data_rdata, 32'hA3);
        set_in(1'b1, 32'h8C, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t4_stall", {31'd0, bus.data_stall}, 32'd1);
        tick();
        chk("t4_novld", {31'd0, bus.data_rvalid}, 32'd0);
        @(negedge clk);
        chk("t4_go", {31'd0, bus.data_stall}, 32'd0);
        tick();
        idle();
        chk("t4_c5v", {31'd0, bus.data_rvalid}, 32'd1);
        chk("t4_c5", bus.data_rdata, 32'hA4);
        wait_empty();
        load(32'h80, "t4_a80", 32'hA1);
        load(32'h8C, "t4_a8c", 32'hA4);

        // Same-cycle load and store to one word.
        set_in(1'b1, 32'h30, 1'b1, 32'h30, 32'd7);
        tick();
        idle();
        chk("t5_old", bus.data_rdata, 32'd5);
        load(32'h30, "t5_new", 32'd7);
        wait_empty();

        // Error flags.
        chk("t6_m0", {31'd0, bus.err_misalign}, 32'd0);
        load(32'h02, "t6_mis", 32'hA0A0_0000);
        chk("t6_m1", {31'd0, bus.err_misalign}, 32'd1);
        chk("t6_r0", {31'd0, bus.err_range}, 32'd0);
        set_in(1'b0, 32'd0, 1'b1, 32'h1000, 32'h1234);
        tick();
        idle();
        chk("t6_r1", {31'd0, bus.err_range}, 32'd1);
        chk("t6_empty", {31'd0, bus.wbuf_empty}, 32'd1);
        load(32'h1000, "t6_oor", 32'd0);
        load(32'h00, "t6_w0", 32'hA0A0_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
